// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard scoreboard.
// Mux select codes, in-flight entry layout and the "writes r" predicate.
package fwd_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } entry_t;

  // True when entry e will write architectural register r ($0 excluded).
  function automatic logic f_writes(
    input entry_t           e,
    input logic [REG_W-1:0] r
  );
    return e.valid & e.reg_write & (e.dest == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-side request bundle and EX-side select/stall responses.
// master = pipeline control driving ID info, slave = scoreboard.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            ex_fwd_sel_a;
  logic [1:0]            ex_fwd_sel_b;
  logic                  stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_uses_rs, id_uses_rt,
    output id_dest, id_reg_write,
    output id_mem_read, flush,
    input  ex_fwd_sel_a, ex_fwd_sel_b,
    input  stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_uses_rs, id_uses_rt,
    input  id_dest, id_reg_write,
    input  id_mem_read, flush,
    output ex_fwd_sel_a, ex_fwd_sel_b,
    output stall, stall_count
  );

endinterface

// File: rtl/fwd_stage_reg.sv
// One in-flight entry slot (EX, MEM or WB) of the scoreboard.
// Bubble input loads an invalid entry instead of the upstream one.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_bubble,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;

  // Advance the entry one stage, or squash it to an invalid slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// EX operand forwarding selects and load-use stall generation.
// Tracks destination registers of in-flight instructions EX->MEM->WB.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic                   Clk,
  input logic                   Reset,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_dest;
  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_rs_hit;
  logic                  w_rt_hit;
  logic [2:0]            w_bub;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;
  entry_t                w_ent [4];
  entry_t                w_ex;
  entry_t                w_mem;

  logic [1:0]            r_sel_a;
  logic [1:0]            r_sel_b;
  logic [CNT_W-1:0]      r_cnt;

  assign w_rs   = bus.id_rs;
  assign w_rt   = bus.id_rt;
  assign w_dest = bus.id_dest;

  assign w_ent[0] = '{
    valid:     bus.id_valid,
    dest:      w_dest,
    reg_write: bus.id_reg_write,
    mem_read:  bus.id_mem_read
  };

  assign w_ex  = w_ent[1];
  assign w_mem = w_ent[2];

  // Only the ID->EX hop can bubble; later stages always shift.
  assign w_bub = {2'b00, w_bubble};

  for (genvar g = 0; g < 3; g++) begin : g_pipe
    fwd_stage_reg u_stage (
      .clk      (Clk),
      .rst      (Reset),
      .i_bubble (w_bub[g]),
      .i_d      (w_ent[g]),
      .o_q      (w_ent[g+1])
    );
  end

  assign w_rs_hit = bus.id_uses_rs & (w_ex.dest == w_rs);
  assign w_rt_hit = bus.id_uses_rt & (w_ex.dest == w_rt);

  // Load in EX whose result the ID instruction needs: no path yet.
  assign w_stall = w_ex.valid & w_ex.mem_read & w_ex.reg_write
                 & (w_ex.dest != '0)
                 & (w_rs_hit | w_rt_hit)
                 & bus.id_valid;

  assign w_bubble = w_stall | bus.flush | ~bus.id_valid;

  // Pick forwarding source for the next EX cycle; youngest wins.
  always_comb begin
    w_sel_a = FWD_REGFILE;
    w_sel_b = FWD_REGFILE;
    if (!w_bubble && bus.id_uses_rs) begin
      if (f_writes(w_ex, w_rs)) begin
        w_sel_a = FWD_EXMEM;
      end else if (f_writes(w_mem, w_rs)) begin
        w_sel_a = FWD_MEMWB;
      end
    end
    if (!w_bubble && bus.id_uses_rt) begin
      if (f_writes(w_ex, w_rt)) begin
        w_sel_b = FWD_EXMEM;
      end else if (f_writes(w_mem, w_rt)) begin
        w_sel_b = FWD_MEMWB;
      end
    end
  end

  // Selects travel with the instruction into EX.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sel_a <= FWD_REGFILE;
      r_sel_b <= FWD_REGFILE;
    end else begin
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign bus.ex_fwd_sel_a = r_sel_a;
  assign bus.ex_fwd_sel_b = r_sel_b;
  assign bus.stall        = w_stall;
  assign bus.stall_count  = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard.
// Narrow counter instance so saturation is reachable quickly.
module tb_fwd_hazard_scoreboard;

  localparam int AW = 5;
  localparam int CW = 8;

  logic Clk;
  logic Reset;
  int   n_pass;
  int   n_chk;

  fwd_hazard_scoreboard_if #(.REG_ADDR_W(AW), .CNT_W(CW)) ifc ();

  fwd_hazard_scoreboard #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(
    input logic          v,
    input logic [AW-1:0] rs,
    input logic          urs,
    input logic [AW-1:0] rt,
    input logic          urt,
    input logic [AW-1:0] dst,
    input logic          rw,
    input logic          mr
  );
    ifc.id_valid     = v;
    ifc.id_rs        = rs;
    ifc.id_uses_rs   = urs;
    ifc.id_rt        = rt;
    ifc.id_uses_rt   = urt;
    ifc.id_dest      = dst;
    ifc.id_reg_write = rw;
    ifc.id_mem_read  = mr;
  endtask

  task automatic drain();
    ifc.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL rst_sel_a got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL rst_sel_b got %0d want 0", ifc.ex_fwd_sel_b);
    else n_pass++;
    n_chk++;
    if (ifc.stall !== 1'b0)
      $display("FAIL rst_stall got %0b want 0", ifc.stall);
    else n_pass++;
    n_chk++;
    if (ifc.stall_count !== 8'd0)
      $display("FAIL rst_cnt got %0d want 0", ifc.stall_count);
    else n_pass++;
    Reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc();
    set_id(1, 3, 1, 0, 0, 5, 1, 1);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd1)
      $display("FAIL mr_sel_a1 got %0d want 1", ifc.ex_fwd_sel_a);
    else n_pass++;
    set_id(1, 5, 1, 0, 0, 7, 1, 0);
    #1;
    n_chk++;
    if (ifc.stall !== 1'b1)
      $display("FAIL mr_stall got %0b want 1", ifc.stall);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.stall_count !== 8'd1)
      $display("FAIL mr_cnt1 got %0d want 1", ifc.stall_count);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd2)
      $display("FAIL mr_sel_a2 got %0d want 2", ifc.ex_fwd_sel_a);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL mr_rst_a got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL mr_rst_b got %0d want 0", ifc.ex_fwd_sel_b);
    else n_pass++;
    n_chk++;
    if (ifc.stall !== 1'b0)
      $display("FAIL mr_rst_stall got %0b want 0", ifc.stall);
    else n_pass++;
    n_chk++;
    if (ifc.stall_count !== 8'd0)
      $display("FAIL mr_rst_cnt got %0d want 0", ifc.stall_count);
    else n_pass++;
    Reset = 1'b0;
    set_id(1, 7, 1, 0, 0, 9, 0, 0);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL mr_stale got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    drain();
  endtask

  task automatic test_exmem_fwd();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc();
    set_id(1, 3, 1, 4, 1, 8, 1, 0);
    #1;
    n_chk++;
    if (ifc.stall !== 1'b0)
      $display("FAIL ex_stall got %0b want 0", ifc.stall);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd1)
      $display("FAIL ex_sel_a got %0d want 1", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL ex_sel_b got %0d want 0", ifc.ex_fwd_sel_b);
    else n_pass++;
    drain();
  endtask

  task automatic test_memwb_fwd();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    set_id(1, 1, 1, 3, 1, 10, 1, 0);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd2)
      $display("FAIL mw_sel_b got %0d want 2", ifc.ex_fwd_sel_b);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL mw_sel_a got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    drain();
  endtask

  task automatic test_youngest();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc();
    set_id(1, 2, 1, 0, 0, 3, 1, 0);
    cyc();
    set_id(1, 3, 1, 3, 1, 11, 1, 0);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd1)
      $display("FAIL yg_sel_a got %0d want 1", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd1)
      $display("FAIL yg_sel_b got %0d want 1", ifc.ex_fwd_sel_b);
    else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    cyc();
    set_id(1, 5, 1, 6, 1, 9, 1, 0);
    #1;
    n_chk++;
    if (ifc.stall !== 1'b1)
      $display("FAIL lu_stall got %0b want 1", ifc.stall);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.stall !== 1'b0)
      $display("FAIL lu_stall_drop got %0b want 0", ifc.stall);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL lu_bubble_a got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.stall_count !== 8'd1)
      $display("FAIL lu_cnt got %0d want 1", ifc.stall_count);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd2)
      $display("FAIL lu_sel_a got %0d want 2", ifc.ex_fwd_sel_a);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL lu_sel_b got %0d want 0", ifc.ex_fwd_sel_b);
    else n_pass++;
    drain();
  endtask

  task automatic test_reg_zero();
    set_id(1, 1, 1, 2, 1, 0, 1, 0);
    cyc();
    set_id(1, 0, 1, 0, 1, 12, 1, 0);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0 || ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL z_sel got %0d/%0d want 0/0",
               ifc.ex_fwd_sel_a, ifc.ex_fwd_sel_b);
    else n_pass++;
    drain();
    set_id(1, 1, 1, 0, 0, 0, 1, 1);
    cyc();
    set_id(1, 0, 1, 0, 1, 13, 1, 0);
    #1;
    n_chk++;
    if (ifc.stall !== 1'b0)
      $display("FAIL z_lw_stall got %0b want 0", ifc.stall);
    else n_pass++;
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0 || ifc.ex_fwd_sel_b !== 2'd0)
      $display("FAIL z_lw_sel got %0d/%0d want 0/0",
               ifc.ex_fwd_sel_a, ifc.ex_fwd_sel_b);
    else n_pass++;
    n_chk++;
    if (ifc.stall_count !== 8'd1)
      $display("FAIL z_cnt got %0d want 1", ifc.stall_count);
    else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    set_id(1, 2, 1, 0, 0, 5, 1, 1);
    cyc();
    set_id(1, 5, 1, 0, 0, 9, 1, 0);
    ifc.flush = 1'b1;
    #1;
    n_chk++;
    if (ifc.stall !== 1'b1)
      $display("FAIL fl_stall got %0b want 1", ifc.stall);
    else n_pass++;
    cyc();
    ifc.flush = 1'b0;
    n_chk++;
    if (ifc.stall_count !== 8'd2)
      $display("FAIL fl_cnt got %0d want 2", ifc.stall_count);
    else n_pass++;
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL fl_sel_a got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    drain();
    set_id(1, 1, 1, 0, 0, 3, 1, 0);
    ifc.flush = 1'b1;
    cyc();
    ifc.flush = 1'b0;
    set_id(1, 3, 1, 0, 0, 14, 0, 0);
    cyc();
    n_chk++;
    if (ifc.ex_fwd_sel_a !== 2'd0)
      $display("FAIL fl_squash got %0d want 0", ifc.ex_fwd_sel_a);
    else n_pass++;
    drain();
  endtask

  task automatic stall_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(1, 5, 1, 0, 0, 5, 1, 1);
      cyc();
      cyc();
    end
  endtask

  task automatic test_saturate();
    stall_pairs(252);
    n_chk++;
    if (ifc.stall_count !== 8'd254)
      $display("FAIL sat_254 got %0d want 254", ifc.stall_count);
    else n_pass++;
    stall_pairs(1);
    n_chk++;
    if (ifc.stall_count !== 8'd255)
      $display("FAIL sat_255 got %0d want 255", ifc.stall_count);
    else n_pass++;
    stall_pairs(5);
    n_chk++;
    if (ifc.stall_count !== 8'd255)
      $display("FAIL sat_hold got %0d want 255", ifc.stall_count);
    else n_pass++;
    drain();
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    Reset  = 1'b1;
    ifc.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    test_mid_reset();
    test_exmem_fwd();
    test_memwb_fwd();
    test_youngest();
    test_load_use();
    test_reg_zero();
    test_flush();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
